stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//  Shares one stack instance (push/pop/peek, data_in/data_out, empty/full) among NUM_REQ requesters.
//  - Round-robin arbitration; one stack operation in flight at a time.
//  - Guards the stack: full/empty misuse returns an error response instead of driving the stack.
//  - Routes each popped/peeked value back to the requester that issued the operation.
// PARAMETERS
//  DATA_WIDTH  8  width of stack entries and request/response data
//  NUM_REQ     4  number of requesters, >=2
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst_n         in   1                   asynchronous active-low reset
//  req_valid     in   NUM_REQ             per-requester operation request
//  req_op        in   2*NUM_REQ           per-requester op, slice i = [2*i+:2]
//  req_data      in   DATA_WIDTH*NUM_REQ  per-requester push data, slice i = [DATA_WIDTH*i+:DATA_WIDTH]
//  req_ready     out  NUM_REQ             one-hot accept pulse, request consumed this cycle
//  rsp_valid     out  NUM_REQ             one-hot completion pulse to the granted requester
//  rsp_data      out  DATA_WIDTH          pop/peek result, valid with rsp_valid
//  rsp_err       out  1                   op rejected (full/empty/reserved), valid with rsp_valid
//  busy          out  1                   FSM not in IDLE
//  stk_push/stk_pop/stk_peek  out  1      stack command strobes, at most one high per cycle
//  stk_data_in   out  DATA_WIDTH          stack push data
//  stk_data_out  in   DATA_WIDTH          stack read data; valid the cycle after pop/peek strobe
//  stk_empty     in   1                   stack status
//  stk_full      in   1                   stack status
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer=0, latched op/data/winner cleared. Reset mid-operation
//   aborts the operation; no rsp_valid is produced for it.
//  Ops: PUSH=2'b00, POP=2'b01, PEEK=2'b10, 2'b11 reserved -> rsp_err=1, stack untouched.
//  FSM:
//   IDLE  : if any req_valid -> pick winner (first valid at/after pointer, wrapping).
//           Pulse req_ready[winner]; latch op/data/index. -> ISSUE. Otherwise stay.
//   ISSUE : evaluate stk_full/stk_empty this cycle.
//           PUSH & !full -> stk_push=1, stk_data_in=data, then RESP.
//           POP|PEEK & !empty -> matching strobe =1, then WAIT.
//           PUSH&full, POP|PEEK&empty, or reserved -> no strobe, err flag set, then RESP.
//   WAIT  : capture stk_data_out into rsp register -> RESP.
//   RESP  : rsp_valid[winner]=1 for exactly one cycle, rsp_err=flag.
//           rsp_data = captured value; 0 for push or error.
//           Pointer <= winner+1 mod NUM_REQ -> IDLE.
//  Latency: accept -> rsp_valid is 2 cycles (push/error) or 3 cycles (pop/peek). No response backpressure.
//  Requester i must hold req_valid/op/data stable until req_ready[i]. Dropping req_valid before the grant withdraws the request.
//  Requests arriving while busy wait; no queueing inside the arbiter.
//  Strobes are registered; no combinational path from req_* to stk_*.
//  PEEK leaves stack depth unchanged. All outputs other than the strobes are 0 when not asserted.
// CONFIGURATION
//  STACK_ARB_PRIO_EN defined: requester 0 has strict priority over all others;
//   requesters 1..NUM_REQ-1 round-robin among themselves when req_valid[0]=0.
//  Not defined: pure round-robin over all NUM_REQ requesters.
// STRUCTURE
//  stack_arb_pkg: op_e (PUSH/POP/PEEK/RSVD, 2-bit), state_e (IDLE/ISSUE/WAIT/RESP), OP_W=2.
//  Sub-module rr_arbiter: combinational one-hot grant from (req vector, pointer).
//   Contains the STACK_ARB_PRIO_EN masking.
//  stack_arbiter holds the FSM, latches, pointer and stack interface.
// TESTING  (DATA_WIDTH=8, NUM_REQ=4, stack DEPTH=4)
//  1 Reset: assert rst_n=0 with req_valid=4'hF -> every output 0. After release, first grant is req 0.
//  2 req0 PUSH 0x24 and req1 PUSH 0x81 in the same cycle -> req0 acked first, then req1.
//    req2 POP -> rsp_valid=4'b0100, rsp_data=0x81, rsp_err=0.
//  3 Four pushes fill the stack; 5th PUSH 0x55 -> rsp_err=1, stk_push never pulses.
//    Four POPs then return the pushed values in reverse order.
//  4 POP on empty stack -> rsp_err=1, rsp_data=0, no strobe.
//    PUSH 0x37, then PEEK -> 0x37, then POP -> 0x37, then stk_empty=1.
//  5 req_valid=4'hF held -> grant order 0,1,2,3,0.
//    With STACK_ARB_PRIO_EN: 0,0,0 until req0 drops, then 1,2,3.
//  6 rst_n low during WAIT of a POP -> no rsp_valid. After release: IDLE, busy=0, pointer=0.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types for the stack arbiter: operation codes and FSM states.
package stack_arb_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Operations that return stack contents to the requester.
  function automatic logic is_read(input op_e op);
    return (op == OP_POP) || (op == OP_PEEK);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at/after ptr_i, wrapping.
// Build option: STACK_ARB_PRIO_EN gives requester 0 strict priority; the
// remaining requesters rotate among themselves while requester 0 is idle.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] req_m;
  logic [PTR_W-1:0]   cand [NUM_REQ];

`ifdef STACK_ARB_PRIO_EN
  // Requester 0 is handled ahead of the rotating search, so hide it there.
  assign req_m = {req_i[NUM_REQ-1:1], 1'b0};
`else
  assign req_m = req_i;
`endif

  // Search order: ptr, ptr+1, ... modulo NUM_REQ (works for non-power-of-2 counts).
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum      = {1'b0, ptr_i} + (PTR_W+1)'(gi);
      assign cand[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                     : sum[PTR_W-1:0];
    end
  endgenerate

  // Pick the first requesting candidate in search order.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
`ifdef STACK_ARB_PRIO_EN
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
      any_o    = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_m[cand[k]]) begin
        gnt_o[cand[k]] = 1'b1;
        idx_o          = cand[k];
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack among NUM_REQ requesters, one operation at a time.
// Every output is registered, so each FSM action shows up the cycle after
// the state that decides it. Because the strobe is registered, stack read
// data arrives while the FSM is in RESP, and that is where it is captured.
// Build option: STACK_ARB_PRIO_EN (see rr_arbiter).
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [OP_W*NUM_REQ-1:0]       req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic                          stk_peek,
  output logic [DATA_WIDTH-1:0]         stk_data_in,
  input  logic [DATA_WIDTH-1:0]         stk_data_out,
  input  logic                          stk_empty,
  input  logic                          stk_full
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, win_q, win_d;
  op_e                    op_q, op_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   err_q, err_d, rd_q, rd_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d, din_q, din_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   push_q, push_d, pop_q, pop_d, peek_q, peek_d;

  logic [OP_W-1:0]        op_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  dat_arr [NUM_REQ];
  logic [NUM_REQ-1:0]     gnt;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]  = req_op[OP_W*gi +: OP_W];
      assign dat_arr[gi] = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Next-state logic for the FSM, latched request and all registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_d        = op_q;
    data_d      = data_q;
    err_d       = err_q;
    rd_d        = rd_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    peek_d      = 1'b0;
    din_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ready_d = gnt;
          win_d   = gnt_idx;
          op_d    = op_e'(op_arr[gnt_idx]);
          data_d  = dat_arr[gnt_idx];
          err_d   = 1'b0;
          rd_d    = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        if (op_q == OP_PUSH && !stk_full) begin
          push_d = 1'b1;
          din_d  = data_q;
        end else if (is_read(op_q) && !stk_empty) begin
          pop_d   = (op_q == OP_POP);
          peek_d  = (op_q == OP_PEEK);
          rd_d    = 1'b1;
          state_d = ST_WAIT;
        end else begin
          // Full push, empty read or reserved op: reject without touching the stack.
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d[win_q] = 1'b1;
        rsp_err_d          = err_q;
        rsp_data_d         = rd_q ? stk_data_out : '0;
        ptr_d              = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      peek_q      <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_q        <= op_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      peek_q      <= peek_d;
      din_q       <= din_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign stk_push    = push_q;
  assign stk_pop     = pop_q;
  assign stk_peek    = peek_q;
  assign stk_data_in = din_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a depth-4 stack environment plus a requester-level
// reference model (queue-based stack, rotating-priority grant rule).
module tb_stack_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [2*NR-1:0] req_op;
  logic [DW*NR-1:0] req_data;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, stk_data_in;
  logic            rsp_err, busy, stk_push, stk_pop, stk_peek;
  logic [DW-1:0]   stk_data_out = '0;
  logic            stk_empty, stk_full;

  stack_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop), .stk_peek(stk_peek),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_empty(stk_empty), .stk_full(stk_full)
  );

  always #5 clk = ~clk;

  // Stack environment: read data appears the cycle after a pop/peek strobe.
  logic [DW-1:0] smem [4];
  int sp = 0, push_cnt = 0, pop_cnt = 0, peek_cnt = 0, bad_cnt = 0;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == 4);
  always @(posedge clk) begin
    if (int'(stk_push) + int'(stk_pop) + int'(stk_peek) > 1) bad_cnt <= bad_cnt + 1;
    if (stk_push) begin
      push_cnt <= push_cnt + 1;
      if (sp < 4) begin smem[sp] <= stk_data_in; sp <= sp + 1; end
      else bad_cnt <= bad_cnt + 1;
    end else if (stk_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (sp > 0) begin stk_data_out <= smem[sp-1]; sp <= sp - 1; end
      else bad_cnt <= bad_cnt + 1;
    end else if (stk_peek) begin
      peek_cnt <= peek_cnt + 1;
      if (sp > 0) stk_data_out <= smem[sp-1];
      else bad_cnt <= bad_cnt + 1;
    end
  end

  // Requester drive state and per-requester op queues.
  logic [NR-1:0] pv;
  logic [1:0]    pop_r [NR];
  logic [DW-1:0] pdat  [NR];
  int            qop   [NR][$];
  int            qdat  [NR][$];

  // Reference model state.
  logic [DW-1:0] ref_q[$];
  int  glog[$];
  int  ptr_m = 0, w = 0, age = 0, lat = 0;
  bit  inflight = 0, idle_prev = 1;
  logic [DW-1:0] exp_d, last_rsp;
  logic exp_e;
  int  e_push = 0, e_pop = 0, e_peek = 0;
  int  n_assert = 0, n_fail = 0;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_op[2*i +: 2]   = pop_r[i];
      req_data[DW*i +: DW] = pdat[i];
    end
    req_valid = pv;
  endtask

  task automatic post(input int r, input int op, input int d);
    qop[r].push_back(op);
    qdat[r].push_back(d);
  endtask

  task automatic load(input int r);
    if (qop[r].size() > 0) begin
      pv[r] = 1'b1; pop_r[r] = 2'(qop[r].pop_front()); pdat[r] = 8'(qdat[r].pop_front());
    end else begin
      pv[r] = 1'b0; pop_r[r] = 2'b00; pdat[r] = '0;
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
`ifdef STACK_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // Model the effect of an accepted op on the abstract stack.
  task automatic accept(input int g);
    w = g; ptr_m = (g + 1) % NR; glog.push_back(g);
    exp_d = '0; exp_e = 1'b1; lat = 2;
    case (int'(pop_r[g]))
      0: if (ref_q.size() < 4) begin ref_q.push_back(pdat[g]); e_push++; exp_e = 1'b0; end
      1: if (ref_q.size() > 0) begin exp_d = ref_q.pop_back(); e_pop++; exp_e = 1'b0; lat = 3; end
      2: if (ref_q.size() > 0) begin exp_d = ref_q[$]; e_peek++; exp_e = 1'b0; lat = 3; end
      default: exp_e = 1'b1;
    endcase
    inflight = 1; age = 0;
    load(g); drive();
  endtask

  // Run all queued ops to completion, checking every cycle against the model.
  task automatic run(input int budget);
    int cyc = 0;
    int g;
    logic [NR-1:0] exp_rdy, exp_rsp;
    bit busy_exp;
    for (int r = 0; r < NR; r++) if (!pv[r]) load(r);
    drive();
    while ((pv != 0 || inflight) && cyc < budget) begin
      @(negedge clk); cyc++;
      if (inflight) age++;
      g = -1; exp_rdy = '0;
      if (idle_prev && pv != 0) begin g = pick(pv, ptr_m); exp_rdy = NR'(1 << g); end
      n_assert++;
      assert (req_ready === exp_rdy) else begin n_fail++; $error("FAIL req_ready: got %b expected %b", req_ready, exp_rdy); end
      exp_rsp = (inflight && age == lat) ? NR'(1 << w) : '0;
      n_assert++;
      assert (rsp_valid === exp_rsp) else begin n_fail++; $error("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_rsp); end
      if (exp_rsp != 0) begin
        last_rsp = rsp_data;
        $display("rsp req%0d data=%h err=%b (expected %h/%b)", w, rsp_data, rsp_err, exp_d, exp_e);
        n_assert++;
        assert (rsp_data === exp_d) else begin n_fail++; $error("FAIL rsp_data: got %h expected %h", rsp_data, exp_d); end
        n_assert++;
        assert (rsp_err === exp_e) else begin n_fail++; $error("FAIL rsp_err: got %b expected %b", rsp_err, exp_e); end
        n_assert++;
        assert ({push_cnt, pop_cnt, peek_cnt, bad_cnt} === {e_push, e_pop, e_peek, 0}) else begin
          n_fail++; $error("FAIL strobes: got push=%0d pop=%0d peek=%0d bad=%0d expected %0d %0d %0d 0",
                           push_cnt, pop_cnt, peek_cnt, bad_cnt, e_push, e_pop, e_peek);
        end
        inflight = 0;
      end else begin
        n_assert++;
        assert ({rsp_data, rsp_err} === '0) else begin n_fail++; $error("FAIL rsp_idle: got %h/%b expected 0", rsp_data, rsp_err); end
      end
      if (g >= 0) accept(g);
      busy_exp = inflight && (age < lat);
      n_assert++;
      assert (busy === busy_exp) else begin n_fail++; $error("FAIL busy: got %b expected %b", busy, busy_exp); end
      idle_prev = !busy_exp;
    end
    n_assert++;
    assert (pv == 0 && !inflight) else begin n_fail++; $error("FAIL timeout: %0d cycles, pending %b", cyc, pv); end
  endtask

  task automatic check_all_zero(input string tag);
    n_assert++;
    assert ({req_ready, rsp_valid, rsp_data, rsp_err, busy, stk_push, stk_pop, stk_peek, stk_data_in} === '0)
    else begin
      n_fail++; $error("FAIL %s: outputs rdy=%b rsp=%b d=%h e=%b busy=%b strobes=%b%b%b din=%h expected all 0",
                       tag, req_ready, rsp_valid, rsp_data, rsp_err, busy, stk_push, stk_pop, stk_peek, stk_data_in);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    for (int i = 0; i < NR; i++) begin pop_r[i] = '0; pdat[i] = '0; end

    // 1: reset with all requests high.
    rst_n = 1'b0; pv = '1; drive();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1; pv = '0; drive();

    // 2: simultaneous pushes, then a pop returns the newest value.
    post(0, 0, 8'h24); post(1, 0, 8'h81); post(2, 1, 0);
    run(40);
    n_assert++;
    assert (last_rsp === 8'h81) else begin n_fail++; $error("FAIL pop_after_push: got %h expected 81", last_rsp); end

    // 3: drain, fill to full, overflow, then pop in reverse order.
    post(3, 1, 0); run(20);
    post(0, 0, 8'hA1); run(20);
    post(1, 0, 8'hB2); run(20);
    post(2, 0, 8'hC3); run(20);
    post(3, 0, 8'hD4); run(20);
    post(0, 0, 8'h55); run(20);
    post(1, 1, 0); run(20);
    post(2, 1, 0); run(20);
    post(3, 1, 0); run(20);
    post(0, 1, 0); run(20);
    n_assert++;
    assert (last_rsp === 8'hA1) else begin n_fail++; $error("FAIL lifo_last: got %h expected a1", last_rsp); end

    // 4: empty pop error, push/peek/pop, stack ends empty.
    post(0, 1, 0); run(20);
    post(1, 0, 8'h37); run(20);
    post(2, 2, 0); run(20);
    post(3, 1, 0); run(20);
    n_assert++;
    assert (stk_empty === 1'b1) else begin n_fail++; $error("FAIL empty_after: got %b expected 1", stk_empty); end

    // 5: all requesters held valid; check grant order.
    glog.delete();
    post(0, 0, 8'h11); post(0, 1, 0); post(1, 0, 8'h22); post(2, 2, 0); post(3, 1, 0);
    run(60);
`ifdef STACK_ARB_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      n_assert++;
      assert (glog.size() > i && glog[i] == exp_order[i]) else begin
        n_fail++; $error("FAIL grant_order[%0d]: got %0d expected %0d", i, (glog.size() > i) ? glog[i] : -1, exp_order[i]);
      end
    end

    // Randomized traffic across all requesters, including reserved ops.
    for (int k = 0; k < 40; k++) post($urandom_range(0, NR-1), $urandom_range(0, 3), $urandom_range(0, 255));
    run(400);

    // 6: reset while a pop is in its wait cycle.
    post(2, 0, 8'hC3); run(20);
    pv = '0; pv[2] = 1'b1; pop_r[2] = 2'b01; pdat[2] = '0; drive();
    for (int i = 0; i < 10 && req_ready == '0; i++) @(negedge clk);
    n_assert++;
    assert (req_ready === 4'b0100) else begin n_fail++; $error("FAIL abort_grant: got %b expected 0100", req_ready); end
    pv = '0; pop_r[2] = 2'b00; drive();
    @(negedge clk);
    n_assert++;
    assert (stk_pop === 1'b1 && busy === 1'b1) else begin n_fail++; $error("FAIL abort_wait: pop=%b busy=%b expected 1 1", stk_pop, busy); end
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_assert++;
      assert ({rsp_valid, busy} === '0) else begin n_fail++; $error("FAIL post_abort: rsp=%b busy=%b expected 0", rsp_valid, busy); end
    end
    ptr_m = 0; inflight = 0; idle_prev = 1;
    // Pointer back at 0: requester 1 must beat requester 3.
    glog.delete();
    post(1, 2, 0); post(3, 1, 0);
    run(40);
    n_assert++;
    assert (glog.size() > 0 && glog[0] == 1) else begin n_fail++; $error("FAIL ptr_reset: got %0d expected 1", (glog.size() > 0) ? glog[0] : -1); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
